// File: rtl/rom_port_arbiter_if.sv
// Request/response port between one ROM requester and the arbiter.
// Requester drives req_valid/req_addr/resp_ready; arbiter drives the rest.
interface rom_port_if #(
    parameter int WORD_SIZE = 32
) ();
    logic                 req_valid;
    logic [31:0]          req_addr;
    logic                 req_ready;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_data;
    logic                 resp_fault;
    logic                 resp_ready;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_fault
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read port between
// port 0 (instruction fetch) and port 1 (debug/loader read-back).
// Ports: clk, rst_n (async, active low); p0/p1 request/response ports;
//   rom_addr (word-aligned byte address to ROM), rom_data (ROM read data).
// One transaction outstanding: IDLE (accept) -> ACCESS (read) -> RESP.
module rom_port_arbiter #(
    parameter int SIZE      = 256,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_port_if.slave            p0,
    rom_port_if.slave            p1,
    output logic [31:0]          rom_addr,
    input  logic [WORD_SIZE-1:0] rom_data
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e               state_q;
    logic                 rr_q;
    logic                 gnt_q;
    logic [29:0]          addr_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                 fault_q;

    logic                 in_idle;
    logic                 any_valid;
    logic                 sel;
    logic [31:0]          sel_addr;
    logic                 sel_fault;
    logic                 gnt_resp_ready;
    logic                 resp_v0;
    logic                 resp_v1;

    assign in_idle   = (state_q == IDLE);
    assign any_valid = p0.req_valid | p1.req_valid;

    // With a single requester it wins; on contention rr_q picks.
    assign sel = (p0.req_valid & p1.req_valid) ? rr_q : p1.req_valid;

    assign sel_addr  = sel ? p1.req_addr : p0.req_addr;
    assign sel_fault = (sel_addr[1:0] != 2'b00)
                     | ({2'b00, sel_addr[31:2]} >= 32'(SIZE));

    assign p0.req_ready = in_idle & p0.req_valid & ~sel;
    assign p1.req_ready = in_idle & p1.req_valid & sel;

    assign gnt_resp_ready = gnt_q ? p1.resp_ready : p0.resp_ready;

    assign resp_v0 = (state_q == RESP) & ~gnt_q;
    assign resp_v1 = (state_q == RESP) & gnt_q;

    assign p0.resp_valid = resp_v0;
    assign p1.resp_valid = resp_v1;
    assign p0.resp_data  = resp_v0 ? data_q : '0;
    assign p1.resp_data  = resp_v1 ? data_q : '0;
    assign p0.resp_fault = resp_v0 & fault_q;
    assign p1.resp_fault = resp_v1 & fault_q;

    // The ROM sees the captured word address in every state.
    assign rom_addr = {addr_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        state_q <= ACCESS;
                        gnt_q   <= sel;
                        rr_q    <= ~sel;
                        addr_q  <= sel_addr[31:2];
                        fault_q <= sel_fault;
                    end
                end
                ACCESS: begin
                    // Faulting accesses keep the latency but return zero.
                    data_q  <= fault_q ? '0 : rom_data;
                    state_q <= RESP;
                end
                RESP: begin
                    if (gnt_resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
